// File: rtl/cpu_turbo_clkgen_if.sv
// Turbo request, hold and generated CPU clock signals between the speed
// control register, the clock generator and the Z80 core.
interface cpu_turbo_clkgen_if;
    logic turbo_enable;
    logic turbo_x2;
    logic hold;
    logic cpu_clken;
    logic cpu_clk;
    logic turbo_active;

    modport master (
        output turbo_enable,
        output turbo_x2,
        output hold,
        input  cpu_clken,
        input  cpu_clk,
        input  turbo_active
    );

    modport slave (
        input  turbo_enable,
        input  turbo_x2,
        input  hold,
        output cpu_clken,
        output cpu_clk,
        output turbo_active
    );
endinterface

// File: rtl/cpu_turbo_clkgen.sv
// Z80 clock-enable generator: 3.5/7 MHz from 28 MHz, glitch-free switching.
// Define CPU_TURBO_14MHZ_EN to add the 14 MHz TURBO2 mode.
module cpu_turbo_clkgen (
    input logic              clk,
    input logic              rst_n,
    cpu_turbo_clkgen_if.slave bus
);

`ifdef CPU_TURBO_14MHZ_EN
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        TURBO  = 2'd1,
        TURBO2 = 2'd2
    } mode_e;
`else
    typedef enum logic {
        NORMAL = 1'b0,
        TURBO  = 1'b1
    } mode_e;
`endif

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    mode_e      mode_q;
    mode_e      mode_d;
    mode_e      target;
    state_e     state_q;
    state_e     state_d;
    logic       held_q;
    logic       held_d;
    logic       tick;
    logic       level;
    logic       boundary;
    logic       differ;

`ifndef CPU_TURBO_14MHZ_EN
    logic unused_x2;
    assign unused_x2 = bus.turbo_x2;
`endif

    always_comb begin
        target = NORMAL;
        if (bus.turbo_enable) begin
`ifdef CPU_TURBO_14MHZ_EN
            target = bus.turbo_x2 ? TURBO2 : TURBO;
`else
            target = TURBO;
`endif
        end
    end

    always_comb begin
        tick  = (cnt_q == 3'd7);
        level = cnt_q[2];
        case (mode_q)
            TURBO: begin
                tick  = (cnt_q[1:0] == 2'b11);
                level = cnt_q[1];
            end
`ifdef CPU_TURBO_14MHZ_EN
            TURBO2: begin
                tick  = cnt_q[0];
                level = cnt_q[0];
            end
`endif
            default: begin
                tick  = (cnt_q == 3'd7);
                level = cnt_q[2];
            end
        endcase
    end

    assign cnt_d    = cnt_q + 3'd1;
    assign boundary = (cnt_q == 3'd7);
    assign differ   = (target != mode_q);

    // Hold is only looked at on tick cycles, so a held tick is skipped
    // whole and the release always lands on a full tick.
    always_comb begin
        held_d = held_q;
        if (tick) begin
            held_d = bus.hold;
        end
    end

    // Every rate has cpu_clk high at cnt 7 and low at cnt 0, so the
    // 7->0 edge is the only point where the mode may change.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (differ && boundary) begin
                    mode_d = target;
                end else if (differ) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (!differ) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    mode_d  = target;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            mode_q  <= NORMAL;
            state_q <= IDLE;
            held_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    assign bus.cpu_clken    = tick & ~bus.hold;
    assign bus.cpu_clk      = held_q | level;
    assign bus.turbo_active = (mode_q != NORMAL);

endmodule
